// File: rtl/rfg_axis_protocol_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rfg_axis_protocol_pkg
// Purpose  : Shared command codes and FSM state encoding for the register-file
//            AXIS protocol decoder.
// Contents : CMD_NOP / CMD_WRITE / CMD_READ command bytes, state_t enum,
//            is_access_cmd() helper.
// Revision : 1.0 - initial release
// ============================================================================
package rfg_axis_protocol_pkg;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LEN   = 3'd2,
    WDATA = 3'd3,
    RREQ  = 3'd4,
    RWAIT = 3'd5,
    ROUT  = 3'd6
  } state_t;

  // True for command bytes that open an ADDR/LEN/payload frame.
  function automatic logic is_access_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rfg_axis_protocol_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rfg_axis_protocol_decoder
// Purpose  : Decodes CMD/ADDR/LEN/payload frames from an 8-bit AXIS byte
//            stream into register-file write and read strobes, and returns
//            read data (or a timeout marker byte) as an AXIS byte stream.
// Ports    : clk, res (async, active-high)
//            s_axis_*     : command/data bytes in
//            m_axis_*     : read-back bytes out (tlast on final burst byte)
//            rfg_*        : register-file address, write/read strobes, data
//            err_*        : one-cycle error pulses
//            busy         : high whenever a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module rfg_axis_protocol_decoder
  import rfg_axis_protocol_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 8,
  parameter int         READ_TIMEOUT = 16,
  parameter logic [7:0] TIMEOUT_BYTE = 8'hEE
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ADDR_WIDTH-1:0] rfg_address,
  output logic                  rfg_write,
  output logic [7:0]            rfg_write_value,
  output logic                  rfg_read,
  input  logic [7:0]            rfg_read_value,
  input  logic                  rfg_read_valid,
  output logic                  err_unknown_cmd,
  output logic                  err_read_timeout,
  output logic                  busy
);

  // The timer counts RWAIT cycles starting at 0 on the cycle after the read
  // strobe; terminating at READ_TIMEOUT-2 places the error pulse exactly
  // READ_TIMEOUT cycles after rfg_read.
  localparam int                      c_TIMER_W    = (READ_TIMEOUT > 2) ? $clog2(READ_TIMEOUT) : 1;
  localparam logic [c_TIMER_W-1:0]    c_TIMER_LAST = c_TIMER_W'(READ_TIMEOUT - 2);
  localparam logic [c_TIMER_W-1:0]    c_TIMER_ONE  = c_TIMER_W'(1);
  localparam logic [ADDR_WIDTH-1:0]   c_ADDR_ONE   = ADDR_WIDTH'(1);

  state_t                  r_state;
  logic                    r_is_read;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_remaining;
  logic [c_TIMER_W-1:0]    r_timer;

  logic [7:0]              r_m_tdata;
  logic                    r_m_tvalid;
  logic                    r_m_tlast;
  logic [ADDR_WIDTH-1:0]   r_rfg_address;
  logic                    r_rfg_write;
  logic [7:0]              r_rfg_write_value;
  logic                    r_rfg_read;
  logic                    r_err_unknown;
  logic                    r_err_timeout;

  logic                    w_s_ready;
  logic                    w_s_hs;
  logic                    w_m_hs;
  logic [ADDR_WIDTH-1:0]   w_addr_byte;
  logic [ADDR_WIDTH-1:0]   w_addr_next;

  // Address byte is zero-extended or truncated to the register address width.
  generate
    if (ADDR_WIDTH >= 8) begin : g_addr_zext
      assign w_addr_byte = ADDR_WIDTH'(s_axis_tdata);
    end else begin : g_addr_trunc
      assign w_addr_byte = s_axis_tdata[ADDR_WIDTH-1:0];
    end
  endgenerate

  // Input is accepted in every state that expects a stream byte; read
  // states stall the stream so a following command is never dropped.
  assign w_s_ready   = (r_state == IDLE) || (r_state == ADDR) ||
                       (r_state == LEN)  || (r_state == WDATA);
  assign w_s_hs      = s_axis_tvalid && w_s_ready;
  assign w_m_hs      = r_m_tvalid && m_axis_tready;
  assign w_addr_next = r_addr + c_ADDR_ONE;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state           <= IDLE;
      r_is_read         <= 1'b0;
      r_addr            <= '0;
      r_remaining       <= '0;
      r_timer           <= '0;
      r_m_tdata         <= '0;
      r_m_tvalid        <= 1'b0;
      r_m_tlast         <= 1'b0;
      r_rfg_address     <= '0;
      r_rfg_write       <= 1'b0;
      r_rfg_write_value <= '0;
      r_rfg_read        <= 1'b0;
      r_err_unknown     <= 1'b0;
      r_err_timeout     <= 1'b0;
    end else begin
      // Strobes and error flags are single-cycle pulses.
      r_rfg_write   <= 1'b0;
      r_rfg_read    <= 1'b0;
      r_err_unknown <= 1'b0;
      r_err_timeout <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (w_s_hs) begin
            if (is_access_cmd(s_axis_tdata)) begin
              r_is_read <= (s_axis_tdata == CMD_READ);
              r_state   <= ADDR;
            end else if (s_axis_tdata != CMD_NOP) begin
              r_err_unknown <= 1'b1;
            end
          end
        end

        ADDR: begin
          if (w_s_hs) begin
            r_addr  <= w_addr_byte;
            r_state <= LEN;
          end
        end

        LEN: begin
          if (w_s_hs) begin
            r_remaining <= s_axis_tdata;
            if (r_is_read) begin
              // Strobe is registered so it is high for the whole RREQ cycle.
              r_rfg_read    <= 1'b1;
              r_rfg_address <= r_addr;
              r_state       <= RREQ;
            end else begin
              r_state <= WDATA;
            end
          end
        end

        WDATA: begin
          if (w_s_hs) begin
            r_rfg_write       <= 1'b1;
            r_rfg_write_value <= s_axis_tdata;
            r_rfg_address     <= r_addr;
            r_addr            <= w_addr_next;
            if (r_remaining == 8'd0) begin
              r_state <= IDLE;
            end else begin
              r_remaining <= r_remaining - 8'd1;
            end
          end
        end

        RREQ: begin
          // rfg_read_valid is deliberately not sampled here.
          r_timer <= '0;
          r_state <= RWAIT;
        end

        RWAIT: begin
          // Valid data takes priority over a coincident timeout.
          if (rfg_read_valid) begin
            r_m_tdata  <= rfg_read_value;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= (r_remaining == 8'd0);
            r_state    <= ROUT;
          end else if (r_timer == c_TIMER_LAST) begin
            r_m_tdata     <= TIMEOUT_BYTE;
            r_m_tvalid    <= 1'b1;
            r_m_tlast     <= (r_remaining == 8'd0);
            r_err_timeout <= 1'b1;
            r_state       <= ROUT;
          end else begin
            r_timer <= r_timer + c_TIMER_ONE;
          end
        end

        ROUT: begin
          if (w_m_hs) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            if (r_remaining == 8'd0) begin
              r_state <= IDLE;
            end else begin
              r_remaining   <= r_remaining - 8'd1;
              r_addr        <= w_addr_next;
              r_rfg_address <= w_addr_next;
              r_rfg_read    <= 1'b1;
              r_state       <= RREQ;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready    = w_s_ready;
  assign m_axis_tdata     = r_m_tdata;
  assign m_axis_tvalid    = r_m_tvalid;
  assign m_axis_tlast     = r_m_tlast;
  assign rfg_address      = r_rfg_address;
  assign rfg_write        = r_rfg_write;
  assign rfg_write_value  = r_rfg_write_value;
  assign rfg_read         = r_rfg_read;
  assign err_unknown_cmd  = r_err_unknown;
  assign err_read_timeout = r_err_timeout;
  assign busy             = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rfg_axis_protocol_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rfg_axis_protocol_decoder
// Purpose  : Directed self-checking bench for rfg_axis_protocol_decoder.
//            A negedge monitor logs strobes and handshakes with cycle stamps;
//            each test task compares those logs against hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rfg_axis_protocol_decoder;

  logic       clk = 1'b0;
  logic       res;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic [7:0] rfg_address;
  logic       rfg_write;
  logic [7:0] rfg_write_value;
  logic       rfg_read;
  logic [7:0] rfg_read_value;
  logic       rfg_read_valid;
  logic       err_unknown_cmd;
  logic       err_read_timeout;
  logic       busy;

  rfg_axis_protocol_decoder #(
    .ADDR_WIDTH  (8),
    .READ_TIMEOUT(16),
    .TIMEOUT_BYTE(8'hEE)
  ) dut (
    .clk             (clk),
    .res             (res),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .rfg_address     (rfg_address),
    .rfg_write       (rfg_write),
    .rfg_write_value (rfg_write_value),
    .rfg_read        (rfg_read),
    .rfg_read_value  (rfg_read_value),
    .rfg_read_valid  (rfg_read_valid),
    .err_unknown_cmd (err_unknown_cmd),
    .err_read_timeout(err_read_timeout),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- event logs ----------------
  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
    logic       l;
  } ev_t;

  ev_t        wr_q[$];
  ev_t        rd_q[$];
  ev_t        mo_q[$];
  ev_t        si_q[$];
  int         eu_q[$];
  int         et_q[$];
  int         stab_err = 0;
  logic       pv = 1'b0, ph = 1'b0, pl = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(negedge clk) begin
    ev_t e;
    if (!res) begin
      e.cyc = cyc; e.a = rfg_address; e.d = rfg_write_value; e.l = 1'b0;
      if (rfg_write) wr_q.push_back(e);
      if (rfg_read)  rd_q.push_back(e);
      if (err_unknown_cmd)  eu_q.push_back(cyc);
      if (err_read_timeout) et_q.push_back(cyc);
      if (m_axis_tvalid && m_axis_tready) begin
        e.d = m_axis_tdata; e.l = m_axis_tlast;
        mo_q.push_back(e);
      end
      if (s_axis_tvalid && s_axis_tready) begin
        e.d = s_axis_tdata;
        si_q.push_back(e);
      end
      // An offered output byte must stay put until it is taken.
      if (pv && !ph && (!m_axis_tvalid || m_axis_tdata != pd || m_axis_tlast != pl))
        stab_err <= stab_err + 1;
    end
    pv <= m_axis_tvalid;
    pd <= m_axis_tdata;
    pl <= m_axis_tlast;
    ph <= m_axis_tvalid && m_axis_tready;
  end

  // ---------------- downstream ready ----------------
  logic tog = 1'b0;
  logic tog_en = 1'b0;
  logic rdy_fix = 1'b1;
  always @(posedge clk) tog <= ~tog;
  assign m_axis_tready = tog_en ? tog : rdy_fix;

  // ---------------- register-file read responder ----------------
  // Answers each rfg_read with the next queued byte, three cycles later.
  bit         resp_en = 1'b0;
  int         rcnt = 0;
  logic [7:0] resp_q[$];

  initial begin
    rfg_read_valid = 1'b0;
    rfg_read_value = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      rfg_read_valid = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0 && resp_q.size() > 0) begin
          rfg_read_valid = 1'b1;
          rfg_read_value = resp_q.pop_front();
        end
      end
      if (rfg_read && resp_en) rcnt = 3;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] tx_q[$];

  task automatic clear_logs();
    wr_q.delete(); rd_q.delete(); mo_q.delete(); si_q.delete();
    eu_q.delete(); et_q.delete(); resp_q.delete();
    stab_err = 0;
  endtask

  // Drives every byte of tx_q back-to-back, holding each until accepted.
  task automatic send_all();
    int n;
    foreach (tx_q[i]) begin
      s_axis_tdata  = tx_q[i];
      s_axis_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_axis_tready && n < 200) begin
        n++;
        @(negedge clk);
      end
      if (!s_axis_tready) begin
        checks++; errors++;
        $display("FAIL send_stall: byte %h never accepted (tready=%b, required 1)", tx_q[i], s_axis_tready);
        break;
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    tx_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int count);
    int n = 0;
    while (mo_q.size() < count && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (mo_q.size() < count) begin
      errors++;
      $display("FAIL out_timeout: got %0d output bytes, required %0d", mo_q.size(), count);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL reset_tready: got %b required 1", s_axis_tready);
    end
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, rfg_address, rfg_write, rfg_write_value,
         rfg_read, err_unknown_cmd, err_read_timeout, busy} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {m_axis_tvalid, m_axis_tlast, m_axis_tdata, rfg_address, rfg_write, rfg_write_value,
                rfg_read, err_unknown_cmd, err_read_timeout, busy});
    end
    @(posedge clk); #1;
    res = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_write_burst();
    logic [7:0] ev[3] = '{8'hAA, 8'hBB, 8'hCC};
    clear_logs();
    tx_q.push_back(8'h01); tx_q.push_back(8'h10); tx_q.push_back(8'h02);
    tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC);
    send_all();
    wait_cycles(3);
    checks++;
    if (wr_q.size() != 3) begin
      errors++; $display("FAIL wr_count: got %0d required 3", wr_q.size());
    end
    checks++;
    if (si_q.size() != 6 || si_q[5].cyc - si_q[0].cyc != 5) begin
      errors++; $display("FAIL wr_stream: got %0d accepted bytes, required 6 consecutive", si_q.size());
    end
    for (int i = 0; i < wr_q.size() && i < 3; i++) begin
      checks++;
      if (wr_q[i].a !== 8'h10 + 8'(i) || wr_q[i].d !== ev[i]) begin
        errors++;
        $display("FAIL wr_data[%0d]: got addr %h val %h required addr %h val %h",
                 i, wr_q[i].a, wr_q[i].d, 8'h10 + 8'(i), ev[i]);
      end
      checks++;
      if (si_q.size() == 6 && wr_q[i].cyc != si_q[3+i].cyc + 1) begin
        errors++;
        $display("FAIL wr_latency[%0d]: got cycle %0d required %0d", i, wr_q[i].cyc, si_q[3+i].cyc + 1);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wr_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_read_wrap();
    logic [7:0] ea[3] = '{8'hFE, 8'hFF, 8'h00};
    logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
    clear_logs();
    resp_q.push_back(8'h11); resp_q.push_back(8'h22); resp_q.push_back(8'h33);
    resp_en = 1'b1;
    tog_en  = 1'b1;
    tx_q.push_back(8'h02); tx_q.push_back(8'hFE); tx_q.push_back(8'h02);
    send_all();
    wait_out(3);
    wait_cycles(3);
    tog_en  = 1'b0;
    resp_en = 1'b0;
    checks++;
    if (rd_q.size() != 3) begin
      errors++; $display("FAIL rd_count: got %0d required 3", rd_q.size());
    end
    for (int i = 0; i < rd_q.size() && i < 3; i++) begin
      checks++;
      if (rd_q[i].a !== ea[i]) begin
        errors++; $display("FAIL rd_addr[%0d]: got %h required %h", i, rd_q[i].a, ea[i]);
      end
    end
    for (int i = 0; i < mo_q.size() && i < 3; i++) begin
      checks++;
      if (mo_q[i].d !== ed[i] || mo_q[i].l !== (i == 2)) begin
        errors++;
        $display("FAIL rd_out[%0d]: got data %h last %b required data %h last %b",
                 i, mo_q[i].d, mo_q[i].l, ed[i], (i == 2));
      end
    end
    checks++;
    if (stab_err != 0 || et_q.size() != 0) begin
      errors++; $display("FAIL rd_stable: got %0d unstable, %0d timeouts, required 0/0", stab_err, et_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rd_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    resp_en = 1'b0;
    tx_q.push_back(8'h02); tx_q.push_back(8'h40); tx_q.push_back(8'h00);
    send_all();
    wait_out(1);
    wait_cycles(2);
    checks++;
    if (et_q.size() != 1 || rd_q.size() != 1) begin
      errors++; $display("FAIL to_count: got %0d pulses %0d reads required 1/1", et_q.size(), rd_q.size());
    end else begin
      checks++;
      if (et_q[0] - rd_q[0].cyc != 16 || rd_q[0].a !== 8'h40) begin
        errors++;
        $display("FAIL to_delay: got %0d cycles at addr %h required 16 at addr 40", et_q[0] - rd_q[0].cyc, rd_q[0].a);
      end
    end
    checks++;
    if (mo_q.size() != 1 || mo_q[0].d !== 8'hEE || mo_q[0].l !== 1'b1) begin
      errors++; $display("FAIL to_byte: got %0d bytes first %h required one byte EE last 1", mo_q.size(), mo_q[0].d);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL to_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_nop_unknown();
    clear_logs();
    tx_q.push_back(8'h00); tx_q.push_back(8'h7F); tx_q.push_back(8'h01);
    tx_q.push_back(8'h05); tx_q.push_back(8'h00); tx_q.push_back(8'h99);
    send_all();
    wait_cycles(3);
    checks++;
    if (eu_q.size() != 1 || si_q.size() != 6 || eu_q[0] != si_q[1].cyc + 1) begin
      errors++; $display("FAIL unk_pulse: got %0d pulses required 1 following byte 7F", eu_q.size());
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0].a !== 8'h05 || wr_q[0].d !== 8'h99) begin
      errors++; $display("FAIL unk_write: got %0d writes first %h/%h required 1 write 05/99", wr_q.size(), wr_q[0].a, wr_q[0].d);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL unk_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_write();
    clear_logs();
    tx_q.push_back(8'h01); tx_q.push_back(8'h30); tx_q.push_back(8'h03); tx_q.push_back(8'hA1);
    send_all();
    wait_cycles(2);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %b required 1", busy);
    end
    @(negedge clk); #1;
    res = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b1 || {m_axis_tvalid, rfg_address, rfg_write, rfg_write_value,
         rfg_read, err_unknown_cmd, err_read_timeout, busy} !== 23'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got busy %b addr %h tready %b required 0/00/1", busy, rfg_address, s_axis_tready);
    end
    wait_cycles(2);
    res = 1'b0;
    wait_cycles(4);
    checks++;
    if (wr_q.size() != 1 || wr_q[0].a !== 8'h30 || wr_q[0].d !== 8'hA1) begin
      errors++; $display("FAIL mid_writes: got %0d writes required only 30/A1", wr_q.size());
    end
    tx_q.push_back(8'h01); tx_q.push_back(8'h20); tx_q.push_back(8'h00); tx_q.push_back(8'h55);
    send_all();
    wait_cycles(3);
    checks++;
    if (wr_q.size() != 2 || wr_q[1].a !== 8'h20 || wr_q[1].d !== 8'h55) begin
      errors++; $display("FAIL mid_new_frame: got %0d writes last %h/%h required 2 with 20/55",
                         wr_q.size(), wr_q[wr_q.size()-1].a, wr_q[wr_q.size()-1].d);
    end
  endtask

  task automatic test_stall_during_read();
    clear_logs();
    resp_q.push_back(8'h5A);
    resp_en = 1'b1;
    rdy_fix = 1'b1;
    tx_q.push_back(8'h02); tx_q.push_back(8'h60); tx_q.push_back(8'h00);
    tx_q.push_back(8'h01); tx_q.push_back(8'h70); tx_q.push_back(8'h00); tx_q.push_back(8'hC3);
    send_all();
    wait_cycles(3);
    resp_en = 1'b0;
    checks++;
    if (mo_q.size() != 1 || mo_q[0].d !== 8'h5A || mo_q[0].l !== 1'b1) begin
      errors++; $display("FAIL stall_out: got %0d bytes first %h required one byte 5A last 1", mo_q.size(), mo_q[0].d);
    end
    checks++;
    if (si_q.size() != 7 || mo_q.size() != 1 || si_q[3].cyc != mo_q[0].cyc + 1) begin
      errors++; $display("FAIL stall_release: got %0d accepted, cmd at %0d required 7, cmd at %0d",
                         si_q.size(), si_q[3].cyc, mo_q[0].cyc + 1);
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0].a !== 8'h70 || wr_q[0].d !== 8'hC3) begin
      errors++; $display("FAIL stall_write: got %0d writes first %h/%h required 1 write 70/C3", wr_q.size(), wr_q[0].a, wr_q[0].d);
    end
  endtask

  initial begin
    res           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_timeout();
    test_nop_unknown();
    test_reset_mid_write();
    test_stall_during_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/rfg_axis_protocol_decoder.md
Name: rfg_axis_protocol_decoder

Overview:
Byte-stream command decoder that consumes the 8-bit AXIS stream from the SPI slave ingress stage. It turns framed commands into register-file write and read strobes, and returns read data as an AXIS byte stream toward the SPI egress path. It runs on one clock in the same domain as the ingress AXIS output and is the protocol layer of the register-file access path.

Parameters:
ADDR_WIDTH, 8, register address width; address byte zero-extended/truncated to this width
READ_TIMEOUT, 16, max clk cycles to wait for rfg_read_valid before timeout (>=2)
TIMEOUT_BYTE, 8'hEE, byte emitted on m_axis when a read times out

Ports:
clk  in  1  block clock
res  in  1  asynchronous reset, active-high
s_axis_tdata  in  8  command/data bytes from the SPI ingress stage
s_axis_tvalid  in  1  input byte valid
s_axis_tready  out  1  decoder accepts byte
m_axis_tdata  out  8  read-back byte
m_axis_tvalid  out  1  read-back byte valid
m_axis_tready  in  1  downstream accepts byte
m_axis_tlast  out  1  last byte of a read burst
rfg_address  out  ADDR_WIDTH  register address for the current access
rfg_write  out  1  one-cycle write strobe
rfg_write_value  out  8  write data
rfg_read  out  1  one-cycle read request strobe
rfg_read_value  in  8  read data
rfg_read_valid  in  1  read data valid; sampled in READ_WAIT only
err_unknown_cmd  out  1  one-cycle pulse on an illegal command byte
err_read_timeout  out  1  one-cycle pulse on a read timeout
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, res=1): state=IDLE. All outputs are 0 except s_axis_tready=1. Internal address, count and timer are cleared. Reset mid-frame abandons the frame with no further strobes.
- Frame format: CMD, ADDR, LEN, then payload. Burst count N=LEN+1 (1..256).
- CMD values: 8'h00=NOP (consumed, stay IDLE); 8'h01=WRITE; 8'h02=READ. Any other value pulses err_unknown_cmd for 1 cycle and stays in IDLE.
- s_axis_tready=1 in IDLE, ADDR, LEN, WDATA; 0 in RREQ, RWAIT, ROUT.
- Handshake: a byte is consumed only when s_axis_tvalid & s_axis_tready. Output tvalid/tdata/tlast are held stable until m_axis_tready.
- States and transitions:
  - IDLE: on WRITE/READ byte -> ADDR.
  - ADDR: latch address -> LEN.
  - LEN: remaining=LEN. WRITE -> WDATA; READ -> RREQ.
  - WDATA: on each accepted byte, the next cycle drives rfg_write=1 with rfg_write_value=byte and rfg_address=current address (latency 1). Address then increments modulo 2^ADDR_WIDTH. After the N-th byte -> IDLE. Back-to-back bytes give one rfg_write per cycle.
  - RREQ: rfg_read=1 for 1 cycle with current rfg_address -> RWAIT; timer cleared.
  - RWAIT: when rfg_read_valid=1, latch rfg_read_value -> ROUT. rfg_read_valid in the same cycle as rfg_read is ignored. When the timer reaches READ_TIMEOUT, latch TIMEOUT_BYTE, pulse err_read_timeout -> ROUT.
  - ROUT: m_axis_tvalid=1, m_axis_tlast=1 when remaining==0. On handshake: if remaining==0 -> IDLE; else decrement remaining, increment address -> RREQ.
- Address wrap: 8'hFF+1 -> 8'h00 with no error. LEN=8'hFF produces 256 accesses.
- Simultaneous rfg_read_valid and timeout-terminal cycle: valid data wins, no error pulse.
- An s_axis byte presented during read states is stalled (tready=0), never dropped.

Decomposition:
- Package rfg_axis_protocol_pkg: command codes CMD_NOP/CMD_WRITE/CMD_READ, state enum {IDLE, ADDR, LEN, WDATA, RREQ, RWAIT, ROUT}.
- No sub-module. Flat FSM plus timer; expected size about 200 lines.

Test Plan:
- Write 01,10,02,AA,BB,CC with tvalid continuous -> rfg_write pulses at addr 10/11/12 with values AA/BB/CC, one per cycle, each 1 cycle after its handshake; busy then 0.
- Read 02,FE,02; slave answers rfg_read_valid 3 cycles after each rfg_read with 11,22,33; m_axis_tready toggling -> m_axis bytes 11,22,33; tlast only on 33; addresses FE,FF,00 (wrap).
- Read 02,40,00 with rfg_read_valid never asserted -> err_read_timeout pulse after 16 cycles; m_axis byte EE with tlast=1; return to IDLE.
- Bytes 00,7F,01,05,00,99 -> NOP ignored; err_unknown_cmd pulse on 7F; single write addr 05 value 99.
- Assert res during WDATA after 1 of 4 bytes -> no further rfg_write, outputs at reset values; new frame 01,20,00,55 writes 55 to 20.
- During read wait, s_axis_tvalid=1 with 01 -> s_axis_tready=0 until the read burst ends; 01 is then consumed as the next CMD.
